// File: rtl/mem_stage.sv
// Pipeline MEM stage: issues one data-memory request per load/store, holds it until ack,
// aligns store data/byte lanes and formats load data into the registered MEM/WB outputs.
module mem_stage (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic [1:0]  i_rd_dest_select,
   input  logic [2:0]  i_store_sel,
   input  logic [2:0]  i_load_sel,
   input  logic        i_dmem_ren,
   input  logic        i_dmem_wen,
   input  logic [31:0] i_alu_result,
   input  logic [31:0] i_immediate,
   input  logic [31:0] i_pc_plus_4,
   input  logic [31:0] i_rs2_data,
   input  logic [4:0]  i_rd_addr,
   input  logic        i_rd_wen,
   output logic        o_dmem_req,
   output logic        o_dmem_we,
   output logic [31:0] o_dmem_addr,
   output logic [31:0] o_dmem_wdata,
   output logic [3:0]  o_dmem_mask,
   input  logic        i_dmem_ack,
   input  logic [31:0] i_dmem_rdata,
   output logic        o_stall,
   output logic        o_wb_valid,
   output logic [4:0]  o_wb_rd_addr,
   output logic        o_wb_rd_wen,
   output logic [31:0] o_wb_data,
   output logic        o_misaligned
);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t      r_state, w_state_next;
   logic        w_access, w_is_store, w_misaligned, w_accept;
   logic [2:0]  w_size;          // one-hot: [0] byte, [1] half, [2] word
   logic [31:0] w_st_wdata, w_ld_shift, w_ld_data;
   logic [3:0]  w_st_mask;

   logic        r_dmem_we;
   logic [31:0] r_dmem_addr, r_dmem_wdata;
   logic [3:0]  r_dmem_mask;
   logic [1:0]  r_byte_off, r_dest;
   logic [2:0]  r_load_sel;
   logic [31:0] r_alu, r_imm, r_pc4;
   logic [4:0]  r_rd_addr;
   logic        r_rd_wen;

   function automatic logic [31:0] f_wb_mux(input logic [1:0]  sel,
                                            input logic [31:0] alu,
                                            input logic [31:0] ld,
                                            input logic [31:0] imm,
                                            input logic [31:0] pc4);
      case (sel)
         2'b00:   return alu;
         2'b01:   return ld;
         2'b10:   return imm;
         default: return pc4;
      endcase
   endfunction

   assign w_is_store = i_dmem_wen;
   assign w_access   = i_valid & (i_dmem_ren | i_dmem_wen);

   always_comb begin
      w_size = 3'b100;
      if (w_is_store) begin
         case (i_store_sel)
            3'b000:  w_size = 3'b001;
            3'b001:  w_size = 3'b010;
            default: w_size = 3'b100;
         endcase
      end else begin
         case (i_load_sel)
            3'b000, 3'b100: w_size = 3'b001;
            3'b001, 3'b101: w_size = 3'b010;
            default:        w_size = 3'b100;
         endcase
      end
   end

   assign w_misaligned = w_access & ((w_size[1] & i_alu_result[0]) |
                                     (w_size[2] & (|i_alu_result[1:0])));
   assign w_accept     = w_access & ~w_misaligned;

   always_comb begin
      w_st_wdata = 32'd0;
      w_st_mask  = 4'b0000;
      if (w_is_store) begin
         if (w_size[0]) begin
            w_st_wdata = {4{i_rs2_data[7:0]}};
            w_st_mask  = 4'b0001 << i_alu_result[1:0];
         end else if (w_size[1]) begin
            w_st_wdata = {2{i_rs2_data[15:0]}};
            w_st_mask  = 4'b0011 << i_alu_result[1:0];
         end else begin
            w_st_wdata = i_rs2_data;
            w_st_mask  = 4'b1111;
         end
      end
   end

   // Load word is returned aligned; move the addressed byte/half down to bit 0.
   assign w_ld_shift = i_dmem_rdata >> {r_byte_off, 3'b000};

   always_comb begin
      case (r_load_sel)
         3'b000:  w_ld_data = {{24{w_ld_shift[7]}},  w_ld_shift[7:0]};
         3'b001:  w_ld_data = {{16{w_ld_shift[15]}}, w_ld_shift[15:0]};
         3'b100:  w_ld_data = {24'd0, w_ld_shift[7:0]};
         3'b101:  w_ld_data = {16'd0, w_ld_shift[15:0]};
         default: w_ld_data = w_ld_shift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept)   w_state_next = BUSY;
         default: if (i_dmem_ack) w_state_next = IDLE;
      endcase
   end

   always_comb begin
      o_dmem_req = 1'b0;
      o_stall    = 1'b0;
      case (r_state)
         IDLE:    o_stall = w_accept;
         default: begin
            o_dmem_req = 1'b1;
            o_stall    = ~i_dmem_ack;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_dmem_we    <= 1'b0;
         r_dmem_addr  <= 32'd0;
         r_dmem_wdata <= 32'd0;
         r_dmem_mask  <= 4'b0000;
         r_byte_off   <= 2'd0;
         r_dest       <= 2'd0;
         r_load_sel   <= 3'd0;
         r_alu        <= 32'd0;
         r_imm        <= 32'd0;
         r_pc4        <= 32'd0;
         r_rd_addr    <= 5'd0;
         r_rd_wen     <= 1'b0;
      end else if (r_state == IDLE && w_accept) begin
         r_dmem_we    <= w_is_store;
         r_dmem_addr  <= {i_alu_result[31:2], 2'b00};
         r_dmem_wdata <= w_st_wdata;
         r_dmem_mask  <= w_st_mask;
         r_byte_off   <= i_alu_result[1:0];
         r_dest       <= i_rd_dest_select;
         r_load_sel   <= i_load_sel;
         r_alu        <= i_alu_result;
         r_imm        <= i_immediate;
         r_pc4        <= i_pc_plus_4;
         r_rd_addr    <= i_rd_addr;
         r_rd_wen     <= i_rd_wen;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         o_wb_valid   <= 1'b0;
         o_wb_rd_addr <= 5'd0;
         o_wb_rd_wen  <= 1'b0;
         o_wb_data    <= 32'd0;
         o_misaligned <= 1'b0;
      end else if (r_state == IDLE) begin
         o_wb_valid   <= i_valid & ~w_accept;
         o_wb_rd_wen  <= i_valid & ~w_access & i_rd_wen;
         o_misaligned <= w_misaligned;
         if (i_valid && !w_accept) begin
            o_wb_rd_addr <= i_rd_addr;
            o_wb_data    <= w_misaligned ? 32'd0 :
                            f_wb_mux(i_rd_dest_select, i_alu_result, 32'd0,
                                     i_immediate, i_pc_plus_4);
         end
      end else begin
         o_wb_valid   <= i_dmem_ack;
         o_wb_rd_wen  <= i_dmem_ack & ~r_dmem_we & r_rd_wen;
         o_misaligned <= 1'b0;
         if (i_dmem_ack) begin
            o_wb_rd_addr <= r_rd_addr;
            o_wb_data    <= f_wb_mux(r_dest, r_alu, w_ld_data, r_imm, r_pc4);
         end
      end
   end

   assign o_dmem_we    = r_dmem_we;
   assign o_dmem_addr  = r_dmem_addr;
   assign o_dmem_wdata = r_dmem_wdata;
   assign o_dmem_mask  = r_dmem_mask;

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized checks of mem_stage against an arithmetic model of the
// load/store/writeback rules.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic [1:0]  i_rd_dest_select;
   logic [2:0]  i_store_sel, i_load_sel;
   logic        i_dmem_ren, i_dmem_wen;
   logic [31:0] i_alu_result, i_immediate, i_pc_plus_4, i_rs2_data;
   logic [4:0]  i_rd_addr;
   logic        i_rd_wen;
   logic        o_dmem_req, o_dmem_we;
   logic [31:0] o_dmem_addr, o_dmem_wdata;
   logic [3:0]  o_dmem_mask;
   logic        i_dmem_ack;
   logic [31:0] i_dmem_rdata;
   logic        o_stall, o_wb_valid, o_wb_rd_wen, o_misaligned;
   logic [4:0]  o_wb_rd_addr;
   logic [31:0] o_wb_data;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk(clk), .rst(rst), .i_valid(i_valid), .i_rd_dest_select(i_rd_dest_select),
      .i_store_sel(i_store_sel), .i_load_sel(i_load_sel),
      .i_dmem_ren(i_dmem_ren), .i_dmem_wen(i_dmem_wen),
      .i_alu_result(i_alu_result), .i_immediate(i_immediate),
      .i_pc_plus_4(i_pc_plus_4), .i_rs2_data(i_rs2_data),
      .i_rd_addr(i_rd_addr), .i_rd_wen(i_rd_wen),
      .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
      .o_dmem_wdata(o_dmem_wdata), .o_dmem_mask(o_dmem_mask),
      .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
      .o_stall(o_stall), .o_wb_valid(o_wb_valid), .o_wb_rd_addr(o_wb_rd_addr),
      .o_wb_rd_wen(o_wb_rd_wen), .o_wb_data(o_wb_data), .o_misaligned(o_misaligned)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference model: access width in bytes
   function automatic int m_size(input logic wen, input logic [2:0] ssel, input logic [2:0] lsel);
      if (wen) return (ssel == 3'd0) ? 1 : (ssel == 3'd1) ? 2 : 4;
      if (lsel == 3'd0 || lsel == 3'd4) return 1;
      if (lsel == 3'd1 || lsel == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] lsel, input logic [31:0] addr,
                                          input logic [31:0] rdata);
      logic [31:0] v, b, h;
      v = rdata / (32'd1 << (8 * (addr % 4)));
      b = v % 256;
      h = v % 65536;
      case (lsel)
         3'd0:    return (b >= 128) ? b - 32'd256 : b;
         3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
         3'd4:    return b;
         3'd5:    return h;
         default: return v;
      endcase
   endfunction

   task automatic idle_cycle(input logic ack);
      i_valid = 1'b0; i_dmem_ren = 1'b0; i_dmem_wen = 1'b0; i_dmem_ack = ack;
      #1;
      chk("idle_req", {31'd0, o_dmem_req}, 32'd0);
      chk("idle_stall", {31'd0, o_stall}, 32'd0);
      tick();
      i_dmem_ack = 1'b0;
      chk("idle_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("idle_wb_rd_wen", {31'd0, o_wb_rd_wen}, 32'd0);
   endtask

   task automatic run_op(input logic [1:0] dest, input logic [2:0] ssel, input logic [2:0] lsel,
                         input logic ren, input logic wen, input logic [31:0] alu,
                         input logic [31:0] imm, input logic [31:0] pc4, input logic [31:0] rs2,
                         input logic [4:0] rd, input logic rdwen, input int delay,
                         input logic [31:0] rdata);
      int  sz, off;
      logic mem, mis;
      logic [31:0] exp_wdata, exp_data;
      logic [3:0]  exp_mask;
      sz  = m_size(wen, ssel, lsel);
      off = int'(alu % 4);
      mem = ren | wen;
      mis = mem && ((alu % sz) != 0);
      exp_wdata = (sz == 1) ? (rs2 % 256) * 32'h0101_0101 :
                  (sz == 2) ? (rs2 % 65536) * 32'h0001_0001 : rs2;
      exp_mask  = (sz == 1) ? 4'(1 << off) : (sz == 2) ? 4'(3 << off) : 4'hF;
      $display("OP dest=%0d ren=%0b wen=%0b ssel=%0d lsel=%0d addr=%h delay=%0d mis=%0b",
               dest, ren, wen, ssel, lsel, alu, delay, mis);
      i_valid = 1'b1; i_rd_dest_select = dest; i_store_sel = ssel; i_load_sel = lsel;
      i_dmem_ren = ren; i_dmem_wen = wen; i_alu_result = alu; i_immediate = imm;
      i_pc_plus_4 = pc4; i_rs2_data = rs2; i_rd_addr = rd; i_rd_wen = rdwen;
      i_dmem_ack = 1'b0;
      #1;
      chk("accept_req", {31'd0, o_dmem_req}, 32'd0);
      chk("accept_stall", {31'd0, o_stall}, {31'd0, mem && !mis});
      tick();
      if (mem && !mis) begin
         for (int d = 0; d <= delay; d++) begin
            chk("busy_wb_valid", {31'd0, o_wb_valid}, 32'd0);
            chk("busy_req", {31'd0, o_dmem_req}, 32'd1);
            chk("busy_we", {31'd0, o_dmem_we}, {31'd0, wen});
            chk("busy_addr", o_dmem_addr, alu - (alu % 4));
            if (wen) begin
               chk("busy_wdata", o_dmem_wdata, exp_wdata);
               chk("busy_mask", {28'd0, o_dmem_mask}, {28'd0, exp_mask});
            end
            if (d == delay) begin
               i_dmem_ack = 1'b1; i_dmem_rdata = rdata;
            end
            #1;
            chk("busy_stall", {31'd0, o_stall}, {31'd0, d != delay});
            tick();
         end
         i_dmem_ack = 1'b0;
         chk("done_req", {31'd0, o_dmem_req}, 32'd0);
      end
      chk("wb_valid", {31'd0, o_wb_valid}, 32'd1);
      chk("wb_misaligned", {31'd0, o_misaligned}, {31'd0, mis});
      chk("wb_rd_wen", {31'd0, o_wb_rd_wen}, {31'd0, rdwen && !wen && !mis});
      chk("wb_rd_addr", {27'd0, o_wb_rd_addr}, {27'd0, rd});
      if (!mis && !wen) begin
         exp_data = (dest == 2'd1) ? m_load(lsel, alu, rdata) :
                    (dest == 2'd0) ? alu : (dest == 2'd2) ? imm : pc4;
         chk("wb_data", o_wb_data, exp_data);
      end
   endtask

   initial begin
      rst = 1'b1; i_valid = 1'b0; i_rd_dest_select = 2'd0; i_store_sel = 3'd0;
      i_load_sel = 3'd0; i_dmem_ren = 1'b0; i_dmem_wen = 1'b0; i_alu_result = 32'd0;
      i_immediate = 32'd0; i_pc_plus_4 = 32'd0; i_rs2_data = 32'd0; i_rd_addr = 5'd0;
      i_rd_wen = 1'b0; i_dmem_ack = 1'b0; i_dmem_rdata = 32'd0;
      repeat (3) tick();
      rst = 1'b0;
      chk("rst_req", {31'd0, o_dmem_req}, 32'd0);
      chk("rst_we", {31'd0, o_dmem_we}, 32'd0);
      chk("rst_addr", o_dmem_addr, 32'd0);
      chk("rst_wdata", o_dmem_wdata, 32'd0);
      chk("rst_mask", {28'd0, o_dmem_mask}, 32'd0);
      chk("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("rst_wb_rd_wen", {31'd0, o_wb_rd_wen}, 32'd0);
      chk("rst_wb_data", o_wb_data, 32'd0);
      chk("rst_misaligned", {31'd0, o_misaligned}, 32'd0);

      // Stray ack while idle must be ignored
      idle_cycle(1'b1);

      // LB 0x103 with ack in the first busy cycle
      run_op(2'd1, 3'd0, 3'd0, 1'b1, 1'b0, 32'h103, 32'd0, 32'd0, 32'd0, 5'd3, 1'b1, 0, 32'h80FF_1234);
      chk("lb_value", o_wb_data, 32'hFFFF_FF80);
      idle_cycle(1'b0);
      // SH 0x202
      run_op(2'd0, 3'd1, 3'd0, 1'b0, 1'b1, 32'h202, 32'd0, 32'd0, 32'hDEAD_BEEF, 5'd4, 1'b1, 0, 32'd0);
      // LW 0x40 with 3-cycle delayed ack
      run_op(2'd1, 3'd0, 3'd2, 1'b1, 1'b0, 32'h40, 32'd0, 32'd0, 32'd0, 5'd5, 1'b1, 3, 32'h1234_5678);
      // LW 0x41 misaligned, then the pulse must drop
      run_op(2'd1, 3'd0, 3'd2, 1'b1, 1'b0, 32'h41, 32'd0, 32'd0, 32'd0, 5'd6, 1'b1, 0, 32'd0);
      idle_cycle(1'b0);
      chk("mis_pulse_end", {31'd0, o_misaligned}, 32'd0);
      // ALU op then JAL back-to-back
      run_op(2'd0, 3'd0, 3'd0, 1'b0, 1'b0, 32'h55, 32'd0, 32'd0, 32'd0, 5'd7, 1'b1, 0, 32'd0);
      run_op(2'd3, 3'd0, 3'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'h1004, 32'd0, 5'd1, 1'b1, 0, 32'd0);
      idle_cycle(1'b0);

      // Reset during BUSY aborts the access; a late ack is ignored
      i_valid = 1'b1; i_dmem_ren = 1'b1; i_dmem_wen = 1'b0; i_load_sel = 3'd2;
      i_rd_dest_select = 2'd1; i_alu_result = 32'h80; i_rd_wen = 1'b1;
      tick();
      chk("abort_busy_req", {31'd0, o_dmem_req}, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0; i_valid = 1'b0; i_dmem_ren = 1'b0;
      chk("abort_req", {31'd0, o_dmem_req}, 32'd0);
      chk("abort_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      i_dmem_ack = 1'b1; i_dmem_rdata = 32'hCAFE_F00D;
      tick();
      i_dmem_ack = 1'b0;
      chk("late_ack_wb_valid", {31'd0, o_wb_valid}, 32'd0);
      chk("late_ack_rd_wen", {31'd0, o_wb_rd_wen}, 32'd0);
      chk("late_ack_req", {31'd0, o_dmem_req}, 32'd0);

      // Randomized mix of ALU ops, loads and stores
      for (int n = 0; n < 80; n++) begin
         int kind;
         logic [2:0] lsel;
         logic [1:0] dest;
         logic [31:0] addr;
         kind = int'($urandom_range(0, 2));
         addr = $urandom;
         if ($urandom_range(0, 3) != 0) addr = addr & ~32'h3 | ($urandom_range(0, 1) ? 32'd0 : 32'd2);
         case ($urandom_range(0, 5))
            0: lsel = 3'd0; 1: lsel = 3'd1; 2: lsel = 3'd2;
            3: lsel = 3'd4; 4: lsel = 3'd5; default: lsel = 3'd7;
         endcase
         dest = 2'($urandom_range(0, 2));
         if (dest == 2'd1) dest = 2'd3;
         if (kind == 0)
            run_op(dest, 3'd0, 3'd0, 1'b0, 1'b0, $urandom, $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom), 0, 32'd0);
         else if (kind == 1)
            run_op(2'd1, 3'd0, lsel, 1'b1, 1'b0, addr, $urandom, $urandom, $urandom,
                   5'($urandom), 1'($urandom), int'($urandom_range(0, 3)), $urandom);
         else
            run_op(2'd0, 3'($urandom_range(0, 7)), lsel, 1'($urandom), 1'b1, addr, $urandom,
                   $urandom, $urandom, 5'($urandom), 1'b1, int'($urandom_range(0, 3)), $urandom);
         if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
